nvme_err_report: RTL and testbench
==================================

// Module: nvme_err_report
// PURPOSE
//  Consumes the sticky per-bit hold vector produced by the nvme_srlat error latch bank.
//  Detects newly set bits, logs them in a write-1-to-clear pending register and captures
//  the first error index with a timestamp. Keeps a saturating event count and runs an
//  interrupt request/ack handshake toward the MMIO/interrupt logic.
//  Status is readable through a simple 32-bit register read/write port.
// PARAMETERS
//  width  128  number of error bits; multiple of 32, 32..1024
//  AW     6    register word-address width; 2**AW >= width/32+3
//  IW     7    index width; IW = clog2(width)
// PORTS
//  clk          in   1      single clock, all logic posedge
//  reset_n      in   1      asynchronous, active-low reset
//  err_in       in   width  sticky hold bits from nvme_srlat hold_out
//  err_mask     in   width  1 = bit is logged but does not request an interrupt
//  int_req      out  1      interrupt request, level, held until int_ack
//  int_ack      in   1      one-cycle acknowledge of int_req
//  reg_rd_v     in   1      read strobe
//  reg_rd_addr  in   AW     read word address
//  reg_rd_data  out  32     read data, valid with reg_rd_ack
//  reg_rd_ack   out  1      one-cycle pulse, 1 cycle after reg_rd_v
//  reg_wr_v     in   1      write strobe
//  reg_wr_addr  in   AW     write word address
//  reg_wr_data  in   32     write data (W1C semantics)
//  first_v      out  1      first-error capture valid
//  first_idx    out  IW     index of first captured error bit
//  first_ts     out  32     timestamp of first capture
//  err_cnt      out  16     saturating count of cycles with any new error
// BEHAVIOUR
//  Reset (reset_n=0, async): seen, pending, first_v/idx/ts, err_cnt, ts counter, reg_rd_*,
//   int_req all 0; FSM=IDLE. Deassertion is sampled synchronously by the registers.
//  seen_q <= err_in each cycle; new = err_in & ~seen_q.
//   A bit that drops and re-rises counts again.
//  pending_q <= (pending_q & ~wclr) | new. wclr = reg_wr_data on the matching pending word.
//   A set wins over a clear in the same cycle.
//  ts counter: free-running 32b, +1 per cycle, wraps 0xFFFFFFFF->0.
//  err_cnt: +1 in any cycle with |new; saturates at 0xFFFF. Cleared by a write to CNT.
//  First capture: if first_v==0 and |new:
//   - first_v<=1
//   - first_idx <= lowest set index of new
//   - first_ts <= ts counter value in that cycle
//   first_v is cleared only by a write to FIRST with bit31=1.
//   If a clear and a new event occur in the same cycle, the new event is captured.
//  Register map (word addr), 1-cycle read latency:
//   0..width/32-1   pending[32k+31:32k]
//   width/32        FIRST {first_v, 31-IW zeros... , first_idx}
//   width/32+1      TS = first_ts
//   width/32+2      CNT = {16'b0, err_cnt}
//   Any other address reads 0; writes to it are ignored.
//   A read in the same cycle as a write returns the pre-write value.
//  Interrupt FSM, unmasked pending um = pending_q & ~err_mask:
//   - IDLE:     int_req=0; |um -> REQ
//   - REQ:      int_req=1; int_ack -> SERVICED
//   - SERVICED: int_req=0; |(new & ~err_mask) -> REQ; else um==0 -> IDLE
//   int_ack outside REQ is ignored. A mask change affects um in the next evaluation.
//  Latency: err_in rise -> pending/first/cnt update 1 cycle later.
//   int_req asserts 1 cycle after pending updates.
// TESTING
//  1. Reset, then err_in[5] rises at ts=10:
//     pending[5]=1, first_idx=5, first_ts=10, err_cnt=1, int_req asserts 2 cycles later.
//  2. err_in[3] and err_in[70] rise in the same cycle:
//     first_idx=3, pending word0 bit3 and word2 bit6 set, err_cnt=1.
//  3. err_mask[9]=1, err_in[9] rises:
//     pending[9]=1, int_req stays 0; clear the mask -> int_req=1 via IDLE->REQ.
//  4. int_ack, then W1C 0x20 to word0 with err_in[5] still high:
//     pending[5]=0, FSM->IDLE, no new int_req.
//  5. Same-cycle W1C of bit 7 and new rise of bit 7:
//     pending[7]=1; write FIRST bit31=1 -> first_v=0; next new event recaptures first.
//  6. Force 0x10000 new events: err_cnt holds 0xFFFF; read of addr width/32+3 returns 0.
//     Assert reset_n=0 mid-REQ: int_req drops immediately, all state zeroed.

Source files
------------

// File: rtl/nvme_err_report.sv
// Error report block: logs rising bits of the srlat hold vector, captures the
// first error with a timestamp and raises a level interrupt until acked.
module nvme_err_report #(
  parameter int width = 128,
  parameter int AW    = 6,
  parameter int IW    = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [width-1:0] err_in,
  input  logic [width-1:0] err_mask,
  output logic             int_req,
  input  logic             int_ack,
  input  logic             reg_rd_v,
  input  logic [AW-1:0]    reg_rd_addr,
  output logic [31:0]      reg_rd_data,
  output logic             reg_rd_ack,
  input  logic             reg_wr_v,
  input  logic [AW-1:0]    reg_wr_addr,
  input  logic [31:0]      reg_wr_data,
  output logic             first_v,
  output logic [IW-1:0]    first_idx,
  output logic [31:0]      first_ts,
  output logic [15:0]      err_cnt
);

  localparam int NW = width / 32;
  localparam logic [AW-1:0] A_FIRST = AW'(NW);
  localparam logic [AW-1:0] A_TS    = AW'(NW + 1);
  localparam logic [AW-1:0] A_CNT   = AW'(NW + 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_SVC  = 2'd2;

  logic [width-1:0] r_seen;
  logic [width-1:0] r_pending;
  logic [31:0]      r_ts;
  logic [15:0]      r_cnt;
  logic             r_first_v;
  logic [IW-1:0]    r_first_idx;
  logic [31:0]      r_first_ts;
  logic [31:0]      r_rd_data;
  logic             r_rd_ack;
  logic [1:0]       r_state;

  logic [width-1:0] w_new;
  logic [width-1:0] w_wclr;
  logic [width-1:0] w_um;
  logic [width-1:0] w_new_um;
  logic [IW-1:0]    w_low_idx;
  logic             w_any_new;
  logic             w_first_clr;
  logic             w_wr_cnt;
  logic             w_capture;
  logic [31:0]      w_pend_word;
  logic [31:0]      w_rd_word;
  logic [1:0]       w_state_nxt;

  assign w_new     = err_in & ~r_seen;
  assign w_any_new = |w_new;
  assign w_um      = r_pending & ~err_mask;
  assign w_new_um  = w_new & ~err_mask;

  assign w_first_clr = reg_wr_v && (reg_wr_addr == A_FIRST)
                       && reg_wr_data[31];
  assign w_wr_cnt    = reg_wr_v && (reg_wr_addr == A_CNT);
  // A clear and a new event in the same cycle re-arm and capture at once
  assign w_capture   = w_any_new && (!r_first_v || w_first_clr);

  always_comb begin
    w_wclr = '0;
    for (int k = 0; k < NW; k++) begin
      if (reg_wr_v && (reg_wr_addr == AW'(k))) begin
        w_wclr[32*k +: 32] = reg_wr_data;
      end
    end
  end

  always_comb begin
    w_low_idx = '0;
    for (int i = width - 1; i >= 0; i--) begin
      if (w_new[i]) begin
        w_low_idx = IW'(i);
      end
    end
  end

  always_comb begin
    w_pend_word = '0;
    for (int k = 0; k < NW; k++) begin
      if (reg_rd_addr == AW'(k)) begin
        w_pend_word = r_pending[32*k +: 32];
      end
    end
  end

  always_comb begin
    w_rd_word = w_pend_word;
    unique case (1'b1)
      (reg_rd_addr == A_FIRST):
        w_rd_word = {r_first_v, {(31-IW){1'b0}}, r_first_idx};
      (reg_rd_addr == A_TS):
        w_rd_word = r_first_ts;
      (reg_rd_addr == A_CNT):
        w_rd_word = {16'b0, r_cnt};
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:
        if (|w_um) w_state_nxt = S_REQ;
      S_REQ:
        if (int_ack) w_state_nxt = S_SVC;
      S_SVC:
        if (|w_new_um) w_state_nxt = S_REQ;
        else if (~|w_um) w_state_nxt = S_IDLE;
      default:
        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_seen    <= '0;
      r_pending <= '0;
      r_ts      <= '0;
    end else begin
      r_seen    <= err_in;
      r_pending <= (r_pending & ~w_wclr) | w_new;
      r_ts      <= r_ts + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_wr_cnt) begin
      r_cnt <= {15'b0, w_any_new};
    end else if (w_any_new && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_first_v   <= 1'b0;
      r_first_idx <= '0;
      r_first_ts  <= '0;
    end else if (w_capture) begin
      r_first_v   <= 1'b1;
      r_first_idx <= w_low_idx;
      r_first_ts  <= r_ts;
    end else if (w_first_clr) begin
      r_first_v   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data <= '0;
      r_rd_ack  <= 1'b0;
    end else begin
      r_rd_ack <= reg_rd_v;
      if (reg_rd_v) begin
        r_rd_data <= w_rd_word;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign int_req     = (r_state == S_REQ);
  assign reg_rd_data = r_rd_data;
  assign reg_rd_ack  = r_rd_ack;
  assign first_v     = r_first_v;
  assign first_idx   = r_first_idx;
  assign first_ts    = r_first_ts;
  assign err_cnt     = r_cnt;

endmodule

// File: tb/tb_nvme_err_report.sv
// Bench for nvme_err_report: directed scenarios plus random traffic,
// checked against a behavioural model through a read scoreboard.
module tb_nvme_err_report;

  localparam int W = 128;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [W-1:0]  err_in;
  logic [W-1:0]  err_mask;
  logic          int_ack;
  logic          reg_rd_v;
  logic [5:0]    rd_addr;
  logic          reg_wr_v;
  logic [5:0]    wr_addr;
  logic [31:0]   wr_data;
  logic          int_req;
  logic [31:0]   reg_rd_data;
  logic          reg_rd_ack;
  logic          first_v;
  logic [6:0]    first_idx;
  logic [31:0]   first_ts;
  logic [15:0]   err_cnt;

  always #5 clk = ~clk;

  nvme_err_report dut (
    .clk(clk), .reset_n(reset_n),
    .err_in(err_in), .err_mask(err_mask),
    .int_req(int_req), .int_ack(int_ack),
    .reg_rd_v(reg_rd_v), .reg_rd_addr(rd_addr),
    .reg_rd_data(reg_rd_data), .reg_rd_ack(reg_rd_ack),
    .reg_wr_v(reg_wr_v), .reg_wr_addr(wr_addr),
    .reg_wr_data(wr_data),
    .first_v(first_v), .first_idx(first_idx),
    .first_ts(first_ts), .err_cnt(err_cnt)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // behavioural model state
  bit [W-1:0]  m_seen;
  bit [W-1:0]  m_pend;
  bit [31:0]   m_ts;
  bit [31:0]   m_fts;
  bit [6:0]    m_fidx;
  bit          m_fv;
  int          m_cnt;
  bit          m_req;
  bit          m_svc;
  logic [31:0] rdq[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mread(input logic [5:0] a);
    int ai = int'(a);
    if (ai < 4) return m_pend[ai*32 +: 32];
    if (ai == 4) return {m_fv, 24'b0, m_fidx};
    if (ai == 5) return m_fts;
    if (ai == 6) return {16'b0, 16'(m_cnt)};
    return 32'd0;
  endfunction

  // one clock: evaluate the rules on current inputs, commit at the edge
  task automatic step();
    bit [W-1:0] nw, clr, um, lb, ein;
    bit [W-1:0] n_pend;
    bit         n_req, n_svc, n_fv, fv;
    bit [6:0]   n_fidx;
    bit [31:0]  n_fts;
    int         n_cnt;
    ein = err_in;
    nw  = ein & ~m_seen;
    clr = '0;
    if (reg_wr_v && wr_addr < 6'd4) clr[int'(wr_addr)*32 +: 32] = wr_data;
    if (reg_rd_v) rdq.push_back(mread(rd_addr));
    um = m_pend & ~err_mask;
    n_req = m_req;
    n_svc = m_svc;
    if (m_req) begin
      if (int_ack) begin n_req = 0; n_svc = 1; end
    end else if (m_svc) begin
      if ((nw & ~err_mask) != 0) begin n_req = 1; n_svc = 0; end
      else if (um == 0) n_svc = 0;
    end else if (um != 0) begin
      n_req = 1;
    end
    fv = m_fv && !(reg_wr_v && wr_addr == 6'd4 && wr_data[31]);
    n_fv = fv;
    n_fidx = m_fidx;
    n_fts = m_fts;
    if (!fv && nw != 0) begin
      lb = nw & (~nw + 1'b1);
      n_fv = 1;
      n_fidx = 7'($countones(lb - 1'b1));
      n_fts = m_ts;
    end
    n_cnt = (reg_wr_v && wr_addr == 6'd6) ? 0 : m_cnt;
    if (nw != 0 && n_cnt < 65535) n_cnt++;
    n_pend = (m_pend & ~clr) | nw;
    @(posedge clk);
    m_seen = ein;
    m_pend = n_pend;
    m_req = n_req;
    m_svc = n_svc;
    m_fv = n_fv;
    m_fidx = n_fidx;
    m_fts = n_fts;
    m_cnt = n_cnt;
    m_ts = m_ts + 1;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    int_ack = 0;
    reg_rd_v = 0;
    rd_addr = '0;
    reg_wr_v = 0;
    wr_addr = '0;
    wr_data = '0;
  endtask

  task automatic rd(input logic [5:0] a);
    reg_rd_v = 1; rd_addr = a;
    step();
    reg_rd_v = 0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    reg_wr_v = 1; wr_addr = a; wr_data = d;
    step();
    reg_wr_v = 0;
  endtask

  task automatic ack();
    int_ack = 1;
    step();
    int_ack = 0;
  endtask

  task automatic do_reset();
    chk_en = 0;
    reset_n = 0;
    err_in = '0;
    err_mask = '0;
    idle_inputs();
    m_seen = '0; m_pend = '0; m_ts = '0; m_fts = '0;
    m_fidx = '0; m_fv = 0; m_cnt = 0; m_req = 0; m_svc = 0;
    rdq.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_int_req", 32'(int_req), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_first_v", 32'(first_v), 32'd0);
    check("rst_rd_ack", 32'(reg_rd_ack), 32'd0);
    reset_n = 1;
    chk_en = 1;
  endtask

  // monitor: compares outputs to the model and pops read responses
  always @(negedge clk) begin
    if (chk_en) begin
      check("int_req", 32'(int_req), 32'(m_req));
      check("first_v", 32'(first_v), 32'(m_fv));
      check("first_idx", 32'(first_idx), 32'(m_fidx));
      check("first_ts", first_ts, m_fts);
      check("err_cnt", 32'(err_cnt), 32'(m_cnt));
      if (reg_rd_ack) begin
        if (rdq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_ack: got unexpected ack want none");
        end else begin
          check("rd_data", reg_rd_data, rdq.pop_front());
        end
      end
    end
  end

  initial begin
    do_reset();

    // first error at ts=10
    repeat (10) step();
    err_in[5] = 1;
    step();
    check("t1_first_v", 32'(first_v), 32'd1);
    check("t1_first_idx", 32'(first_idx), 32'd5);
    check("t1_first_ts", first_ts, 32'd10);
    check("t1_err_cnt", 32'(err_cnt), 32'd1);
    check("t1_int_early", 32'(int_req), 32'd0);
    step();
    check("t1_int_req", 32'(int_req), 32'd1);
    rd(6'd0);
    step();

    // ack then W1C with the source still high
    ack();
    check("t4_after_ack", 32'(int_req), 32'd0);
    wr(6'd0, 32'h20);
    repeat (3) step();
    check("t4_no_int", 32'(int_req), 32'd0);
    rd(6'd0);
    step();

    // two bits rising together after re-arming first and count
    wr(6'd4, 32'h8000_0000);
    wr(6'd6, 32'h0);
    err_in[3] = 1;
    err_in[70] = 1;
    step();
    check("t2_first_idx", 32'(first_idx), 32'd3);
    check("t2_err_cnt", 32'(err_cnt), 32'd1);
    rd(6'd0);
    rd(6'd2);
    rd(6'd4);
    step();

    // masked bit logs but does not interrupt until unmasked
    ack();
    wr(6'd0, 32'hFFFF_FFFF);
    wr(6'd2, 32'hFFFF_FFFF);
    repeat (3) step();
    err_mask[9] = 1;
    err_in[9] = 1;
    repeat (4) step();
    check("t3_masked", 32'(int_req), 32'd0);
    rd(6'd0);
    err_mask[9] = 0;
    step();
    check("t3_unmasked", 32'(int_req), 32'd1);

    // same-cycle W1C and rise of bit 7, then re-arm first capture
    ack();
    err_in[7] = 1;
    wr(6'd0, 32'h80);
    rd(6'd0);
    wr(6'd4, 32'h8000_0000);
    check("t5_first_clr", 32'(first_v), 32'd0);
    err_in[100] = 1;
    step();
    check("t5_recapture", 32'(first_idx), 32'd100);
    rd(6'd4);
    rd(6'd5);
    step();

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(2) == 0) begin
        int b = int'($urandom_range(W - 1));
        err_in[b] = ~err_in[b];
      end
      if ($urandom_range(9) == 0) begin
        int b = int'($urandom_range(W - 1));
        err_mask[b] = ~err_mask[b];
      end
      int_ack = ($urandom_range(3) == 0);
      reg_rd_v = ($urandom_range(1) == 1);
      rd_addr = 6'($urandom_range(9));
      reg_wr_v = ($urandom_range(4) == 0);
      wr_addr = 6'($urandom_range(7));
      wr_data = $urandom;
      step();
    end
    idle_inputs();
    err_mask = '0;
    step();

    // saturate the event counter with a new event every cycle
    chk_en = 0;
    for (int i = 0; i < 65540; i++) begin
      err_in = (i % 2 == 0) ? W'(1) : W'(2);
      step();
    end
    chk_en = 1;
    check("t6_cnt_sat", 32'(err_cnt), 32'hFFFF);
    rd(6'd7);
    rd(6'd6);
    rd(6'd63);
    step();
    check("t6_int_held", 32'(int_req), 32'd1);

    // asynchronous reset in the middle of a request
    chk_en = 0;
    #2 reset_n = 0;
    #1;
    check("t6_rst_int", 32'(int_req), 32'd0);
    check("t6_rst_cnt", 32'(err_cnt), 32'd0);
    check("t6_rst_fv", 32'(first_v), 32'd0);
    check("t6_rst_fts", first_ts, 32'd0);
    check("t6_rst_fidx", 32'(first_idx), 32'd0);
    check("rd_left", 32'(rdq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
